// File: rtl/cd_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : cd_spi_slave
// Purpose  : SPI mode-0 slave front end for the CDBUS register file.
//            Oversamples NSS/SCLK/MOSI in the clk domain, decodes a command
//            byte followed by a data burst, issues single-cycle csr_read /
//            csr_write strobes and shifts read data out on MISO.
// Revision : 1.0 - initial release
// ============================================================================
module cd_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_nss,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       chip_select,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata
);

  // NSS and SCLK carry one extra flop beyond the synchronizer for edge detect.
  localparam int C_EDGE_LEN = SYNC_STAGES + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [C_EDGE_LEN-1:0]   nss_sr_q, nss_sr_d;
  logic [C_EDGE_LEN-1:0]   sclk_sr_q, sclk_sr_d;
  logic [SYNC_STAGES-1:0]  mosi_sr_q, mosi_sr_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              rx_sr_q, rx_sr_d;
  logic [7:0]              tx_sr_q, tx_sr_d;
  logic [4:0]              csr_address_q, csr_address_d;
  logic [7:0]              csr_writedata_q, csr_writedata_d;
  logic                    csr_read_q, csr_read_d;
  logic                    csr_write_q, csr_write_d;
  logic                    chip_select_q, chip_select_d;

  logic                    nss_sync;
  logic                    nss_rise;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    mosi_sync;
  logic [7:0]              rx_byte;

  // Pin synchronizer chains and edge detection against the trailing flop.
  always_comb begin
    nss_sr_d  = {nss_sr_q[SYNC_STAGES-1:0], spi_nss};
    sclk_sr_d = {sclk_sr_q[SYNC_STAGES-1:0], spi_sclk};
    mosi_sr_d = {mosi_sr_q[SYNC_STAGES-2:0], spi_mosi};
    nss_sync  = nss_sr_q[SYNC_STAGES-1];
    nss_rise  = nss_sr_q[SYNC_STAGES-1] & ~nss_sr_q[SYNC_STAGES];
    sclk_rise = sclk_sr_q[SYNC_STAGES-1] & ~sclk_sr_q[SYNC_STAGES];
    sclk_fall = ~sclk_sr_q[SYNC_STAGES-1] & sclk_sr_q[SYNC_STAGES];
    mosi_sync = mosi_sr_q[SYNC_STAGES-1];
    rx_byte   = {rx_sr_q[6:0], mosi_sync};
  end

  // Transaction FSM: command decode, strobe scheduling and shift registers.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    rx_sr_d         = rx_sr_q;
    tx_sr_d         = tx_sr_q;
    csr_address_d   = csr_address_q;
    csr_writedata_d = csr_writedata_q;
    csr_read_d      = 1'b0;
    csr_write_d     = 1'b0;
    chip_select_d   = chip_select_q;

    // A read fetch cycle captures the register data for the next MISO byte;
    // the state handling below may still override it (IDLE / deselect).
    if (csr_read_q) begin
      tx_sr_d = csr_readdata;
    end

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d     = 3'd0;
        rx_sr_d       = 8'd0;
        tx_sr_d       = 8'd0;
        chip_select_d = 1'b0;
        // Level test, so a still-low NSS after reset also starts a transaction.
        if (!nss_sync) begin
          state_d       = ST_CMD;
          chip_select_d = 1'b1;
        end
      end
      default: begin
        if (nss_rise) begin
          // Deselect wins over any coincident SCLK edge; partial byte dropped.
          state_d       = ST_IDLE;
          chip_select_d = 1'b0;
          bit_cnt_d     = 3'd0;
          rx_sr_d       = 8'd0;
          tx_sr_d       = 8'd0;
        end else begin
          if (sclk_rise) begin
            rx_sr_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                ST_CMD: begin
                  csr_address_d = rx_byte[4:0];
                  if (rx_byte[7]) begin
                    state_d = ST_WR;
                  end else begin
                    state_d    = ST_RD;
                    csr_read_d = 1'b1;
                  end
                end
                ST_WR: begin
                  csr_write_d     = 1'b1;
                  csr_writedata_d = rx_byte;
                end
                ST_RD: begin
                  csr_read_d = 1'b1;
                end
                default: begin
                end
              endcase
            end
          end
          // No shift on the fall right after a byte boundary: that would drop
          // the MSB just loaded by the fetch.
          if (sclk_fall && (bit_cnt_q != 3'd0)) begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset; NSS chain resets high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      nss_sr_q        <= '1;
      sclk_sr_q       <= '0;
      mosi_sr_q       <= '0;
      bit_cnt_q       <= 3'd0;
      rx_sr_q         <= 8'd0;
      tx_sr_q         <= 8'd0;
      csr_address_q   <= 5'd0;
      csr_writedata_q <= 8'd0;
      csr_read_q      <= 1'b0;
      csr_write_q     <= 1'b0;
      chip_select_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      nss_sr_q        <= nss_sr_d;
      sclk_sr_q       <= sclk_sr_d;
      mosi_sr_q       <= mosi_sr_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_sr_q         <= rx_sr_d;
      tx_sr_q         <= tx_sr_d;
      csr_address_q   <= csr_address_d;
      csr_writedata_q <= csr_writedata_d;
      csr_read_q      <= csr_read_d;
      csr_write_q     <= csr_write_d;
      chip_select_q   <= chip_select_d;
    end
  end

  assign spi_miso      = tx_sr_q[7];
  assign spi_miso_oe   = chip_select_q;
  assign chip_select   = chip_select_q;
  assign csr_address   = csr_address_q;
  assign csr_read      = csr_read_q;
  assign csr_write     = csr_write_q;
  assign csr_writedata = csr_writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_cd_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_cd_spi_slave
// Purpose  : Directed self-checking bench for cd_spi_slave (SPI mode 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cd_spi_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_nss;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       chip_select;
  logic [4:0] csr_address;
  logic       csr_read;
  logic [7:0] csr_readdata;
  logic       csr_write;
  logic [7:0] csr_writedata;

  int n_vec = 0;
  int n_err = 0;

  // Strobe monitor state
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         both_cnt = 0;
  logic [4:0] wlog_addr [64];
  logic [7:0] wlog_data [64];

  // Register read model: successive reads return successive table entries
  logic [7:0] rd_vals [8];
  logic [2:0] rd_idx = 3'd0;
  logic [2:0] rd_base = 3'd0;
  logic [2:0] rd_sel;

  always #5 clk = ~clk;

  cd_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .spi_nss       (spi_nss),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .chip_select   (chip_select),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_readdata  (csr_readdata),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata)
  );

  assign rd_sel       = rd_idx - rd_base;
  assign csr_readdata = rd_vals[rd_sel];

  always @(posedge clk) begin
    if (csr_read) rd_idx <= rd_idx + 3'd1;
  end

  always @(negedge clk) begin
    if (csr_write) begin
      wlog_addr[wr_cnt % 64] <= csr_address;
      wlog_data[wr_cnt % 64] <= csr_writedata;
      wr_cnt <= wr_cnt + 1;
    end
    if (csr_read) rd_cnt <= rd_cnt + 1;
    if (csr_read && csr_write) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: drive MOSI, sample MISO just before each SCLK rise
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input int half,
                          output logic [7:0] rx);
    logic [7:0] sh;
    sh = tx;
    rx = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = sh[7];
      sh       = {sh[6:0], 1'b0};
      clk_wait(half);
      rx       = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      clk_wait(half);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int half, output logic [7:0] rx);
    spi_bits(tx, 8, half, rx);
  endtask

  task automatic nss_low();
    spi_nss = 1'b0;
    clk_wait(6);
  endtask

  task automatic nss_high();
    clk_wait(4);
    spi_nss = 1'b1;
    clk_wait(8);
  endtask

  initial begin
    logic [7:0] rx;
    int w0, r0;
    logic [7:0] exp_b [3];

    reset = 1'b1; spi_nss = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    for (int i = 0; i < 8; i++) rd_vals[i] = 8'h00;
    clk_wait(4);
    chk("rst_ctrl", {chip_select, spi_miso, spi_miso_oe, csr_read, csr_write}, 5'b0);
    chk("rst_addr", csr_address, 5'h00);
    chk("rst_wdata", csr_writedata, 8'h00);
    reset = 1'b0;
    clk_wait(4);
    chk("idle_cs", chip_select, 1'b0);

    // Single write
    w0 = wr_cnt; r0 = rd_cnt;
    nss_low();
    chk("sel_cs", chip_select, 1'b1);
    chk("sel_oe", spi_miso_oe, 1'b1);
    spi_byte(8'h84, 4, rx);
    chk("wr_cmd_miso", rx, 8'h00);
    spi_byte(8'h0A, 4, rx);
    nss_high();
    chk("wr_cnt", wr_cnt - w0, 1);
    chk("wr_addr", wlog_addr[w0 % 64], 5'h04);
    chk("wr_data", wlog_data[w0 % 64], 8'h0A);
    chk("wr_no_rd", rd_cnt - r0, 0);
    chk("wr_cs_off", chip_select, 1'b0);

    // Burst write to a FIFO address
    w0 = wr_cnt;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    nss_low();
    spi_byte(8'h95, 4, rx);
    for (int i = 0; i < 3; i++) spi_byte(exp_b[i], 4, rx);
    nss_high();
    chk("bw_cnt", wr_cnt - w0, 3);
    for (int i = 0; i < 3; i++) begin
      chk("bw_addr", wlog_addr[(w0 + i) % 64], 5'h15);
      chk("bw_data", wlog_data[(w0 + i) % 64], exp_b[i]);
    end

    // Single read
    r0 = rd_cnt; w0 = wr_cnt;
    rd_base = rd_idx;
    rd_vals[0] = 8'h0F; rd_vals[1] = 8'hEE;
    nss_low();
    spi_byte(8'h00, 4, rx);
    clk_wait(4);
    chk("rd_cnt_cmd", rd_cnt - r0, 1);
    spi_byte(8'h00, 4, rx);
    chk("rd_miso", rx, 8'h0F);
    nss_high();
    chk("rd_cnt_end", rd_cnt - r0, 2);
    chk("rd_addr", csr_address, 5'h00);
    chk("rd_no_wr", wr_cnt - w0, 0);

    // Read burst
    r0 = rd_cnt;
    rd_base = rd_idx;
    rd_vals[0] = 8'hA1; rd_vals[1] = 8'hB2; rd_vals[2] = 8'hC3; rd_vals[3] = 8'h5A;
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
    nss_low();
    spi_byte(8'h14, 4, rx);
    chk("rb_cmd_miso", rx, 8'h00);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'hFF, 4, rx);
      chk("rb_miso", rx, exp_b[i]);
    end
    nss_high();
    chk("rb_cnt", rd_cnt - r0, 4);
    chk("rb_addr", csr_address, 5'h14);

    // Abort mid data byte
    w0 = wr_cnt;
    nss_low();
    spi_byte(8'h84, 4, rx);
    spi_bits(8'hFF, 5, 4, rx);
    clk_wait(4);
    spi_nss = 1'b1;
    clk_wait(2);
    chk("ab_cs_hold", chip_select, 1'b1);
    clk_wait(1);
    chk("ab_cs_drop", chip_select, 1'b0);
    clk_wait(8);
    chk("ab_no_wr", wr_cnt - w0, 0);
    nss_low();
    spi_byte(8'h84, 4, rx);
    spi_byte(8'h55, 4, rx);
    nss_high();
    chk("ab_next_cnt", wr_cnt - w0, 1);
    chk("ab_next_addr", wlog_addr[w0 % 64], 5'h04);
    chk("ab_next_data", wlog_data[w0 % 64], 8'h55);

    // Reset during a data byte
    w0 = wr_cnt; r0 = rd_cnt;
    nss_low();
    spi_byte(8'h84, 4, rx);
    spi_bits(8'hF0, 3, 4, rx);
    reset = 1'b1;
    clk_wait(1);
    chk("mr_ctrl", {chip_select, spi_miso, spi_miso_oe, csr_read, csr_write}, 5'b0);
    chk("mr_addr", csr_address, 5'h00);
    chk("mr_wdata", csr_writedata, 8'h00);
    spi_nss = 1'b1;
    clk_wait(4);
    reset = 1'b0;
    clk_wait(10);
    chk("mr_idle_cs", chip_select, 1'b0);
    chk("mr_no_wr", wr_cnt - w0, 0);
    chk("mr_no_rd", rd_cnt - r0, 0);

    // Reset released while NSS is still low starts a new transaction
    w0 = wr_cnt;
    spi_nss = 1'b0;
    reset = 1'b1;
    clk_wait(3);
    reset = 1'b0;
    clk_wait(6);
    chk("rl_cs", chip_select, 1'b1);
    spi_byte(8'h84, 4, rx);
    spi_byte(8'h77, 4, rx);
    nss_high();
    chk("rl_cnt", wr_cnt - w0, 1);
    chk("rl_data", wlog_data[w0 % 64], 8'h77);

    // Slow SCLK (half period 20 clk)
    w0 = wr_cnt;
    nss_low();
    spi_byte(8'h9F, 20, rx);
    spi_byte(8'hC4, 20, rx);
    nss_high();
    chk("slow_cnt", wr_cnt - w0, 1);
    chk("slow_addr", wlog_addr[w0 % 64], 5'h1F);
    chk("slow_data", wlog_data[w0 % 64], 8'hC4);

    // Random NSS pulses without SCLK
    w0 = wr_cnt; r0 = rd_cnt;
    for (int i = 0; i < 12; i++) begin
      spi_nss = 1'b0;
      clk_wait($urandom_range(1, 12));
      spi_nss = 1'b1;
      clk_wait($urandom_range(1, 12));
    end
    clk_wait(8);
    chk("gap_no_wr", wr_cnt - w0, 0);
    chk("gap_no_rd", rd_cnt - r0, 0);
    chk("gap_cs", chip_select, 1'b0);
    chk("no_overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
